// File: rtl/hp_fifo_array_if.sv
// hp_fifo_array_if: host write / parasite read bundle for the FIFO array.
// master drives strobes and selects, slave returns data and status.
interface hp_fifo_array_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                h_we;
  logic [CHANNELS-1:0] h_select;
  logic [WIDTH-1:0]    h_data;
  logic                p_rd;
  logic [CHANNELS-1:0] p_select;
  logic                one_byte_mode;
  logic [WIDTH-1:0]    p_data;
  logic [CHANNELS-1:0] p_data_available;
  logic [CHANNELS-1:0] p_two_available;
  logic [CHANNELS-1:0] h_full;
  logic [CHANNELS-1:0] h_overrun;
  logic [CHANNELS-1:0] p_underrun;

  modport master (
    output h_we, h_select, h_data,
    output p_rd, p_select, one_byte_mode,
    input  p_data, p_data_available,
    input  p_two_available, h_full,
    input  h_overrun, p_underrun
  );

  modport slave (
    input  h_we, h_select, h_data,
    input  p_rd, p_select, one_byte_mode,
    output p_data, p_data_available,
    output p_two_available, h_full,
    output h_overrun, p_underrun
  );
endinterface

// File: rtl/hp_fifo_array.sv
// hp_fifo_array: CHANNELS independent host-to-parasite byte FIFOs.
// Optional per-channel flush port under HP_FIFO_ARRAY_FLUSH_EN.
module hp_fifo_array #(
  parameter int                CHANNELS      = 4,
  parameter int                WIDTH         = 8,
  parameter int                DEPTH         = 2,
  parameter logic [CHANNELS-1:0] ONE_BYTE_MASK = 4'b0100
) (
  input logic h_phi2,
  input logic h_rst,
`ifdef HP_FIFO_ARRAY_FLUSH_EN
  input logic [CHANNELS-1:0] h_flush,
`endif
  hp_fifo_array_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem    [CHANNELS][DEPTH];
  logic [PW-1:0]       wr_ptr [CHANNELS];
  logic [PW-1:0]       rd_ptr [CHANNELS];
  logic [CW-1:0]       count  [CHANNELS];
  logic [CW-1:0]       cap    [CHANNELS];
  logic [CHANNELS-1:0] ovr, udr;
  logic [CHANNELS-1:0] sel_h, sel_p;
  logic [CHANNELS-1:0] push, pop;
  logic [CHANNELS-1:0] push_ok, pop_ok;
  logic [CHANNELS-1:0] flush;

`ifdef HP_FIFO_ARRAY_FLUSH_EN
  assign flush = h_flush;
`else
  assign flush = '0;
`endif

  // Two's-complement trick isolates the lowest set bit.
  assign sel_h = bus.h_select & (~bus.h_select + 1'b1);
  assign sel_p = bus.p_select & (~bus.p_select + 1'b1);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cap[i] = (bus.one_byte_mode && ONE_BYTE_MASK[i])
             ? CW'(1) : CW'(DEPTH);
      push[i]    = bus.h_we & sel_h[i];
      pop[i]     = bus.p_rd & sel_p[i];
      pop_ok[i]  = pop[i] & (count[i] != '0);
      push_ok[i] = push[i] & ((count[i] < cap[i]) | pop_ok[i]);
    end
  end

  always_ff @(posedge h_phi2) begin
    if (h_rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ovr <= '0;
      udr <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (flush[i]) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
          ovr[i]    <= 1'b0;
          udr[i]    <= 1'b0;
        end else begin
          if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop_ok[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
          if (push_ok[i] && !pop_ok[i])
            count[i] <= count[i] + 1'b1;
          else if (pop_ok[i] && !push_ok[i])
            count[i] <= count[i] - 1'b1;
          if (push[i] && !push_ok[i]) ovr[i] <= 1'b1;
          if (pop[i] && !pop_ok[i])   udr[i] <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge h_phi2) begin
    for (int i = 0; i < CHANNELS; i++)
      if (!h_rst && !flush[i] && push_ok[i])
        mem[i][wr_ptr[i]] <= bus.h_data;
  end

  always_comb begin
    bus.p_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.p_data_available[i] = count[i] >= CW'(1);
      bus.p_two_available[i]  = count[i] >= CW'(2);
      bus.h_full[i]           = count[i] >= cap[i];
      if (sel_p[i] && count[i] != '0)
        bus.p_data = mem[i][rd_ptr[i]];
    end
  end

  assign bus.h_overrun  = ovr;
  assign bus.p_underrun = udr;

endmodule

// File: tb/tb_hp_fifo_array.sv
// tb_hp_fifo_array: directed plan plus random traffic against a
// queue-based reference model of the FIFO array.
module tb_hp_fifo_array;

  localparam int         CH    = 4;
  localparam int         DEPTH = 2;
  localparam logic [3:0] MASK  = 4'b0100;

  logic       h_phi2 = 1'b0;
  logic       h_rst  = 1'b0;
  logic [3:0] flush  = '0;
  int         errors = 0;
  int         checks = 0;

  logic [7:0] q [CH][$];
  logic [3:0] m_ovr, m_udr;

  hp_fifo_array_if #(.CHANNELS(CH), .WIDTH(8)) bus ();

  hp_fifo_array #(
    .CHANNELS(CH), .WIDTH(8), .DEPTH(DEPTH), .ONE_BYTE_MASK(MASK)
  ) dut (
    .h_phi2 (h_phi2),
    .h_rst  (h_rst),
`ifdef HP_FIFO_ARRAY_FLUSH_EN
    .h_flush(flush),
`endif
    .bus    (bus.slave)
  );

  always #5 h_phi2 = ~h_phi2;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < CH; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic model(input logic we, input logic [3:0] hs,
                       input logic [7:0] hd, input logic rd,
                       input logic [3:0] ps, input logic obm,
                       input logic [3:0] fl, input logic rst);
    int sh, sp, cap;
    bit pok, hok;
    sh = lowest(hs);
    sp = lowest(ps);
    for (int c = 0; c < CH; c++) begin
      if (rst || fl[c]) begin
        q[c].delete();
        m_ovr[c] = 1'b0;
        m_udr[c] = 1'b0;
        continue;
      end
      cap = (obm && MASK[c]) ? 1 : DEPTH;
      pok = rd && sp == c && q[c].size() > 0;
      if (rd && sp == c && !pok) m_udr[c] = 1'b1;
      hok = we && sh == c && (q[c].size() < cap || pok);
      if (we && sh == c && !hok) m_ovr[c] = 1'b1;
      if (pok) void'(q[c].pop_front());
      if (hok) q[c].push_back(hd);
    end
  endtask

  task automatic compare(input logic [3:0] ps, input logic obm);
    logic [3:0] av, two, full;
    logic [7:0] pd;
    int sp, cap;
    sp = lowest(ps);
    for (int c = 0; c < CH; c++) begin
      cap     = (obm && MASK[c]) ? 1 : DEPTH;
      av[c]   = q[c].size() >= 1;
      two[c]  = q[c].size() >= 2;
      full[c] = q[c].size() >= cap;
    end
    pd = (sp >= 0 && q[sp].size() > 0) ? q[sp][0] : 8'h00;
    check("p_data", 32'(bus.p_data), 32'(pd));
    check("avail", 32'(bus.p_data_available), 32'(av));
    check("two", 32'(bus.p_two_available), 32'(two));
    check("full", 32'(bus.h_full), 32'(full));
    check("overrun", 32'(bus.h_overrun), 32'(m_ovr));
    check("underrun", 32'(bus.p_underrun), 32'(m_udr));
  endtask

  task automatic step(input logic we, input logic [3:0] hs,
                      input logic [7:0] hd, input logic rd,
                      input logic [3:0] ps, input logic obm,
                      input logic [3:0] fl, input logic rst);
    bus.h_we          = we;
    bus.h_select      = hs;
    bus.h_data        = hd;
    bus.p_rd          = rd;
    bus.p_select      = ps;
    bus.one_byte_mode = obm;
`ifdef HP_FIFO_ARRAY_FLUSH_EN
    flush = fl;
`else
    flush = '0;
`endif
    h_rst = rst;
    @(posedge h_phi2);
    model(we, hs, hd, rd, ps, obm, flush, rst);
    #1;
    compare(ps, obm);
  endtask

  initial begin
    bus.h_we = 0; bus.h_select = 0; bus.h_data = 0;
    bus.p_rd = 0; bus.p_select = 0; bus.one_byte_mode = 0;
    m_ovr = '0; m_udr = '0;

    // reset with a coincident strobe that must be ignored
    step(1, 4'b0001, 8'hEE, 1, 4'b0010, 0, 0, 1);
    check("rst_avail", 32'(bus.p_data_available), 0);
    check("rst_pdata", 32'(bus.p_data), 0);

    step(1, 4'b0001, 8'hA5, 0, 4'b0000, 0, 0, 0);
    step(1, 4'b0001, 8'h3C, 0, 4'b0001, 0, 0, 0);
    check("ch0_full", 32'(bus.h_full[0]), 1);
    check("ch0_two", 32'(bus.p_two_available[0]), 1);
    check("ch0_head", 32'(bus.p_data), 32'h A5);

    step(1, 4'b0001, 8'h77, 0, 4'b0001, 0, 0, 0);
    check("ch0_ovr", 32'(bus.h_overrun[0]), 1);
    check("ch0_keep", 32'(bus.p_data), 32'h A5);
    step(0, 4'b0000, 8'h00, 1, 4'b0001, 0, 0, 0);
    check("ch0_pop", 32'(bus.p_data), 32'h 3C);
    check("ch0_notfull", 32'(bus.h_full[0]), 0);
    check("ch0_sticky", 32'(bus.h_overrun[0]), 1);

    step(1, 4'b0100, 8'h11, 0, 4'b0100, 1, 0, 0);
    check("ch2_obm_full", 32'(bus.h_full[2]), 1);
    step(1, 4'b0100, 8'h12, 0, 4'b0100, 1, 0, 0);
    check("ch2_obm_ovr", 32'(bus.h_overrun[2]), 1);

    step(1, 4'b0010, 8'h21, 0, 4'b0010, 1, 0, 0);
    step(1, 4'b0010, 8'h22, 0, 4'b0010, 1, 0, 0);
    step(1, 4'b0010, 8'h55, 1, 4'b0010, 1, 0, 0);
    check("ch1_both_two", 32'(bus.p_two_available[1]), 1);
    check("ch1_both_ovr", 32'(bus.h_overrun[1]), 0);
    check("ch1_head", 32'(bus.p_data), 32'h 22);
    step(0, 4'b0000, 8'h00, 1, 4'b0010, 1, 0, 0);
    check("ch1_next", 32'(bus.p_data), 32'h 55);

    step(1, 4'b1000, 8'h99, 1, 4'b1000, 0, 0, 0);
    check("ch3_udr", 32'(bus.p_underrun[3]), 1);
    check("ch3_avail", 32'(bus.p_data_available[3]), 1);
    check("ch3_data", 32'(bus.p_data), 32'h 99);

`ifdef HP_FIFO_ARRAY_FLUSH_EN
    step(1, 4'b0001, 8'h01, 0, 4'b0001, 0, 0, 0);
    step(1, 4'b0001, 8'h02, 0, 4'b0001, 0, 0, 0);
    step(1, 4'b0001, 8'h44, 0, 4'b0001, 0, 4'b0001, 0);
    check("fl_avail", 32'(bus.p_data_available[0]), 0);
    check("fl_ovr", 32'(bus.h_overrun[0]), 0);
`endif

    step(0, 4'b0000, 8'h00, 0, 4'b0001, 0, 0, 1);
    check("rst2_avail", 32'(bus.p_data_available), 0);
    check("rst2_flags", 32'({bus.h_overrun, bus.p_underrun}), 0);

    for (int n = 0; n < 800; n++) begin
      logic obm;
      obm = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 1), 4'($urandom), 8'($urandom),
           $urandom_range(0, 1), 4'($urandom), obm,
           ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0,
           $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hp_fifo_array.md
# hp_fifo_array

Parametrised host-to-parasite FIFO array, the next generation of the Tube host-to-parasite register set. It provides CHANNELS independent byte FIFOs of configurable depth, with per-channel one-byte mode and sticky overrun/underrun reporting. All channels run in a single clock domain. Host writes and parasite reads arrive as one-cycle strobes from the bus front-ends.

## Interface
Parameters:
- CHANNELS, 4, number of FIFO channels (1–8)
- WIDTH, 8, data width in bits
- DEPTH, 2, entries per channel; power of two, ≥2
- ONE_BYTE_MASK, 4'b0100, CHANNELS-bit mask; a set bit makes that channel obey one_byte_mode

Ports:
- h_phi2  in  1  clock; all state updates on its rising edge
- h_rst  in  1  reset; synchronous, active-high
- h_we  in  1  host write strobe, one cycle per write
- h_select  in  CHANNELS  host channel select; lowest set bit wins
- h_data  in  WIDTH  host write data
- p_rd  in  1  parasite read strobe, one cycle per read
- p_select  in  CHANNELS  parasite channel select; lowest set bit wins
- one_byte_mode  in  1  limits capacity of masked channels to 1
- h_flush  in  CHANNELS  per-channel flush; present only with HP_FIFO_ARRAY_FLUSH_EN
- p_data  out  WIDTH  head entry of the selected channel
- p_data_available  out  CHANNELS  count[i] ≥ 1
- p_two_available  out  CHANNELS  count[i] ≥ 2
- h_full  out  CHANNELS  count[i] ≥ cap[i]
- h_overrun  out  CHANNELS  sticky: a write to channel i was dropped
- p_underrun  out  CHANNELS  sticky: a read of empty channel i occurred

## Operation
- Per-channel state:
  - storage[DEPTH] of WIDTH bits
  - wr_ptr and rd_ptr, clog2(DEPTH) bits each, wrapping modulo DEPTH
  - count, clog2(DEPTH+1) bits
- Capacity: cap[i] = 1 if (one_byte_mode & ONE_BYTE_MASK[i]), else DEPTH.
- Push on channel i: h_we & sel_h[i], where sel_h is the one-hot lowest-set-bit form of h_select.
  - Accepted if count < cap, or if a pop on channel i occurs in the same cycle.
  - Accepted push: storage[wr_ptr] <= h_data; wr_ptr++.
  - Rejected push: data dropped; h_overrun[i] <= 1.
- Pop on channel i: p_rd & sel_p[i], where sel_p is derived from p_select the same way.
  - Accepted if count ≥ 1: rd_ptr++.
  - Rejected (count = 0): p_underrun[i] <= 1.
- Count update: +1 for push only, −1 for pop only, unchanged for both or neither.
- Empty channel with simultaneous push and pop: the pop is rejected (underrun set), the push is accepted, and count becomes 1.
- p_data is combinational: storage[rd_ptr] of the sel_p channel. It is 0 when no bit of p_select is set or the selected channel is empty.
- Mode change: setting one_byte_mode while count > 1 discards nothing.
  - h_full asserts immediately.
  - The existing entries drain normally.
  - Further pushes are rejected until count < cap.
- Sticky flags clear only on h_rst, or on flush of that channel.
- The host and parasite may address different channels in the same cycle; the channels are fully independent.

## Timing
- Reset (h_rst high at a clock edge): all counts, pointers, h_full, p_data_available, p_two_available, h_overrun and p_underrun are 0.
  - p_data = 0.
  - Storage contents are not reset.
  - A strobe coincident with reset is ignored.
  - Reset mid-operation discards all queued data.
- Write-to-read latency: 1 cycle. A byte pushed at edge N appears on p_data (if it is the head) and on the flags after edge N.
- Pop: the next entry is presented after the same edge that accepts the pop.
- All status outputs decode directly from registered count and flags; no extra pipeline.
- Strobes are level-sampled each cycle. A strobe held for k cycles performs k operations.

## Configuration
- HP_FIFO_ARRAY_FLUSH_EN defined:
  - The h_flush port exists.
  - h_flush[i] high at an edge zeroes count, pointers, h_overrun[i] and p_underrun[i] of channel i.
  - Flush takes priority over a push or pop on that channel in the same cycle; the strobe is dropped and no flag is set.
- HP_FIFO_ARRAY_FLUSH_EN undefined: the port and logic are absent; only h_rst empties channels.

## Test plan
- Reset, then push 0xA5 and 0x3C to ch0 (DEPTH=2) → after 2nd edge h_full[0]=1, p_two_available[0]=1; p_select=0001 gives p_data=0xA5; one pop gives 0x3C, h_full[0]=0.
- ch0 full, push 0x77 → dropped, h_overrun[0]=1 and sticky; a pop then returns 0xA5, not 0x77.
- one_byte_mode=1, push 0x11 to ch2 → h_full[2]=1 after 1 byte; second push sets h_overrun[2]; ch0 still accepts 2 bytes.
- ch1 full, simultaneous push 0x55 and pop → count stays 2, no overrun; the next two pops return the old 2nd byte, then 0x55.
- Pop of empty ch3 with simultaneous push 0x99 → p_underrun[3]=1, p_data_available[3]=1, p_data=0x99.
- (FLUSH_EN) ch0 holds 2 bytes with overrun set; h_flush[0] plus push in the same cycle → count 0, flags cleared, push dropped; h_rst while ch0 holds data → all outputs 0.
